// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Loads the instruction memory at boot from a host byte stream. The stream is
// a 16-bit big-endian word count N followed by 4*N bytes. Each group of four
// bytes is assembled MSB first into one 32-bit word. Words are written to
// consecutive addresses starting at 0. The CPU is held in stall while a load
// is in progress.
//
// Handshake: a byte moves only on a rising edge where byte_valid && byte_ready.
// byte_ready is decoded from the state alone. The host must hold byte_data
// stable while byte_valid is high and byte_ready is low.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   one-cycle pulse, begins a load from IDLE/DONE/ERR
//   byte_valid in   host byte present on byte_data
//   byte_data  in   host byte [7:0]
//   byte_ready out  loader accepts a byte this cycle (LEN_HI/LEN_LO/DATA)
//   mem_we     out  registered one-cycle instruction memory write strobe
//   mem_waddr  out  word write address [ADDR_WIDTH-1:0]
//   mem_wdata  out  word write data [DATA_WIDTH-1:0]
//   cpu_stall  out  high while loading or while a write is pending
//   done       out  level, load finished
//   error      out  level, word count exceeded memory capacity
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  cpu_stall,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Capacity in words. N equal to this is legal; anything larger is rejected.
    localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_words_left;
    logic [1:0]            r_byte_idx;
    logic [23:0]           r_word;       // first three bytes of the word in flight
    logic [ADDR_WIDTH-1:0] r_waddr;

    logic                  w_xfer;
    logic [15:0]           w_len;
    logic                  w_too_big;
    logic                  w_last_byte;
    logic                  w_last_word;
    logic                  w_loading;

    assign w_xfer      = byte_valid && byte_ready;
    // Full count is evaluated in the same cycle the low byte arrives.
    assign w_len       = {r_len_hi, byte_data};
    assign w_too_big   = {16'd0, w_len} > CAP;
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = (r_words_left == 16'd1);
    assign w_loading   = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                         (r_state == S_DATA);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured in IDLE, DONE and ERR.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LEN_HI;
            S_LEN_HI: if (w_xfer) w_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_len == 16'd0)  w_next = S_DONE;
                    else if (w_too_big)  w_next = S_ERR;
                    else                 w_next = S_DATA;
                end
            end
            S_DATA:   if (w_xfer && w_last_byte && w_last_word) w_next = S_DONE;
            S_DONE:   if (start) w_next = S_LEN_HI;
            S_ERR:    if (start) w_next = S_LEN_HI;
            default:  w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs. mem_we is in cpu_stall so the CPU cannot resume
    // while the final word is still being written.
    always_comb begin
        byte_ready = w_loading;
        cpu_stall  = w_loading || mem_we;
        done       = (r_state == S_DONE);
        error      = (r_state == S_ERR);
    end

    // Datapath: length capture, word assembly and write sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len_hi     <= 8'd0;
            r_words_left <= 16'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 24'd0;
            r_waddr      <= '0;
            mem_we       <= 1'b0;
            mem_waddr    <= '0;
            mem_wdata    <= '0;
        end else begin
            mem_we <= 1'b0;
            if ((r_state == S_LEN_HI) && w_xfer) begin
                r_len_hi <= byte_data;
            end
            if ((r_state == S_LEN_LO) && w_xfer) begin
                r_words_left <= w_len;
                r_byte_idx   <= 2'd0;
                r_waddr      <= '0;
            end
            if ((r_state == S_DATA) && w_xfer) begin
                r_word     <= {r_word[15:0], byte_data};
                r_byte_idx <= r_byte_idx + 2'd1;
                if (w_last_byte) begin
                    mem_we       <= 1'b1;
                    mem_wdata    <= {r_word, byte_data};
                    mem_waddr    <= r_waddr;
                    // After a full-capacity load this wraps to 0 but is never used.
                    r_waddr      <= r_waddr + ADDR_WIDTH'(1);
                    r_words_left <= r_words_left - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    // ADDR_WIDTH=12 instance
    logic        byte_ready, mem_we, cpu_stall, done, error;
    logic [11:0] mem_waddr;
    logic [31:0] mem_wdata;

    // ADDR_WIDTH=4 instance, same input stream
    logic        byte_ready4, mem_we4, cpu_stall4, done4, error4;
    logic [3:0]  mem_waddr4;
    logic [31:0] mem_wdata4;

    int n_cmp;
    int n_err;

    logic [43:0] exp_q[$];
    logic [35:0] exp4_q[$];
    logic [7:0]  stim[$];

    imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_stall(cpu_stall), .done(done), .error(error)
    );

    imem_boot_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready4), .mem_we(mem_we4),
        .mem_waddr(mem_waddr4), .mem_wdata(mem_wdata4),
        .cpu_stall(cpu_stall4), .done(done4), .error(error4)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop on every write strobe
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wr12_unexpected: got addr %0h data %0h expected no write", mem_waddr, mem_wdata);
            end else begin
                logic [43:0] e;
                e = exp_q.pop_front();
                if ({mem_waddr, mem_wdata} !== e) begin
                    n_err++;
                    $display("FAIL wr12: got %0h/%0h expected %0h/%0h", mem_waddr, mem_wdata, e[43:32], e[31:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_we4 === 1'b1) begin
            n_cmp++;
            if (exp4_q.size() == 0) begin
                n_err++;
                $display("FAIL wr4_unexpected: got addr %0h data %0h expected no write", mem_waddr4, mem_wdata4);
            end else begin
                logic [35:0] e;
                e = exp4_q.pop_front();
                if ({mem_waddr4, mem_wdata4} !== e) begin
                    n_err++;
                    $display("FAIL wr4: got %0h/%0h expected %0h/%0h", mem_waddr4, mem_wdata4, e[35:32], e[31:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({addr[11:0], data});
        exp4_q.push_back({addr[3:0], data});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit got;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (byte_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("handshake", 64'(got), 64'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_stim(input bit gaps);
        for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gaps);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && (exp_q.size() != 0 || exp4_q.size() != 0); i++) @(posedge clk);
        #1;
        check(name, 64'(exp_q.size() + exp4_q.size()), 64'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_data = 8'h00;
        #3;
        check("reset_flags", {59'd0, byte_ready, mem_we, cpu_stall, done, error}, 64'd0);
        check("reset_waddr", 64'(mem_waddr), 64'd0);
        check("reset_wdata", 64'(mem_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 64'(byte_ready), 64'd0);

        // Nominal two-word load
        expect_write(0, 32'hDEADBEEF);
        expect_write(1, 32'h0000002A);
        pulse_start();
        check("lenhi_ready", {62'd0, byte_ready, cpu_stall}, 64'd3);
        stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
        send_stim(1'b0);
        check("nom_last_we", 64'(mem_we), 64'd1);
        check("nom_last_stall", 64'(cpu_stall), 64'd1);
        check("nom_done", 64'(done), 64'd1);
        @(posedge clk); #1;
        check("nom_stall_fall", {61'd0, cpu_stall, done, mem_we}, 64'b010);
        check("done_ready", 64'(byte_ready), 64'd0);
        wait_drain("nom_drain");

        // Same stream with valid gaps
        expect_write(0, 32'hDEADBEEF);
        expect_write(1, 32'h0000002A);
        pulse_start();
        send_stim(1'b1);
        @(posedge clk); #1;
        check("gap_done", {62'd0, done, cpu_stall}, 64'b10);
        wait_drain("gap_drain");

        // Zero length
        pulse_start();
        send_byte(8'h00, 1'b0);
        check("zero_lenlo_stall", 64'(cpu_stall), 64'd1);
        send_byte(8'h00, 1'b0);
        check("zero_done", {61'd0, done, cpu_stall, mem_we}, 64'b100);
        repeat (3) @(posedge clk);

        // Over capacity (4097)
        pulse_start();
        stim = '{8'h10, 8'h01};
        send_stim(1'b0);
        check("ovf_error", {62'd0, error, error4}, 64'b11);
        check("ovf_outs", {61'd0, cpu_stall, byte_ready, done}, 64'd0);
        repeat (3) @(posedge clk); #1;
        check("ovf_hold", 64'(error), 64'd1);
        expect_write(0, 32'h11223344);
        pulse_start();
        check("ovf_restart_clear", 64'(error), 64'd0);
        stim = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stim(1'b0);
        check("ovf_reload_done", {62'd0, done, done4}, 64'b11);
        wait_drain("ovf_drain");

        // Full capacity for the 4-bit instance: 16 words, addresses 0..15
        stim = '{8'h00, 8'h10};
        for (int i = 0; i < 16; i++) begin
            stim.push_back(8'(i));
            stim.push_back(~8'(i));
            stim.push_back(8'h5A);
            stim.push_back(8'hC3);
            expect_write(i, {8'(i), ~8'(i), 8'h5A, 8'hC3});
        end
        pulse_start();
        send_stim(1'b0);
        check("full_done", {60'd0, done, done4, error, error4}, 64'b1100);
        repeat (10) @(posedge clk);
        wait_drain("full_drain");

        // 17 words: legal for 12-bit, rejected by 4-bit instance
        pulse_start();
        stim = '{8'h00, 8'h11};
        send_stim(1'b0);
        check("n17_err4", {62'd0, error4, byte_ready4}, 64'b10);
        check("n17_data12", {62'd0, error, byte_ready}, 64'b01);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Mid-load asynchronous reset after 6 data bytes
        expect_write(0, 32'hDEADBEEF);
        pulse_start();
        stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};
        send_stim(1'b0);
        check("mid_stall", 64'(cpu_stall), 64'd1);
        check("mid_wdata", 64'(mem_wdata), 64'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_flags", {59'd0, byte_ready, mem_we, cpu_stall, done, error}, 64'd0);
        check("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        check("mid_rst_waddr", 64'(mem_waddr), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_drain("mid_drain1");
        expect_write(0, 32'hDEADBEEF);
        expect_write(1, 32'h0000002A);
        pulse_start();
        stim = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h2A};
        send_stim(1'b1);
        check("mid_reload_done", 64'(done), 64'd1);
        wait_drain("mid_drain2");
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
